// File: rtl/i2s_tdm_receiver.sv
// I2S / TDM serial audio receiver: slot framing on sck, one word per slot into a
// first-word-fall-through FIFO with valid/ready output and sticky status flags.
module i2s_tdm_receiver #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned TDM_MODE   = 0,
  parameter int unsigned DATA_DELAY = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  sck,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  sd,
  input  logic                  ws,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CHW-1:0]        m_chan,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  synced,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clr_status
);

  localparam int unsigned CW = $clog2(SLOT_WIDTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + CHW + 1;
  localparam logic [CHW-1:0] LastChan = CHW'(CHANNELS - 1);

  typedef enum logic [1:0] {StUnsync, StCapture, StSkip} state_e;

  state_e                state_q, state_d;
  logic                  ws_q, ws_qq;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CHW-1:0]        chan_q, chan_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  overflow_q, frame_err_q;

  logic                  ws_cur, ws_prev, ws_edge, frame_start;
  logic                  slot_start, lose_sync, err_set;
  logic [CHW-1:0]        start_chan;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic [CHW-1:0]        push_chan;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  full, pop, wr_ok, ovf_set;

  // With one bit of data delay the edge is judged one register later.
  assign ws_cur      = (DATA_DELAY != 0) ? ws_q  : ws;
  assign ws_prev     = (DATA_DELAY != 0) ? ws_qq : ws_q;
  assign ws_edge     = ws_cur ^ ws_prev;
  assign frame_start = (TDM_MODE != 0) ? (ws_cur & ~ws_prev) : (~ws_cur & ws_prev);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    chan_d     = chan_q;
    shift_d    = shift_q;
    push       = 1'b0;
    push_data  = '0;
    push_chan  = chan_q;
    err_set    = 1'b0;
    slot_start = 1'b0;
    start_chan = '0;
    lose_sync  = 1'b0;

    if (TDM_MODE != 0) begin
      if (frame_start) begin
        slot_start = 1'b1;
        if (state_q != StUnsync &&
            !(bit_cnt_q == CW'(SLOT_WIDTH) && chan_q == LastChan)) begin
          err_set = 1'b1;
        end
      end else if (state_q != StUnsync && bit_cnt_q == CW'(SLOT_WIDTH)) begin
        if (chan_q == LastChan) begin
          err_set   = 1'b1;
          lose_sync = 1'b1;
        end else begin
          slot_start = 1'b1;
          start_chan = chan_q + 1'b1;
        end
      end
    end else begin
      slot_start = (state_q == StUnsync) ? frame_start : ws_edge;
      start_chan = CHW'(ws_cur);
    end

    if (!en) begin
      state_d   = StUnsync;
      bit_cnt_d = '0;
      chan_d    = '0;
      err_set   = 1'b0;
    end else if (lose_sync) begin
      state_d = StUnsync;
    end else if (slot_start) begin
      // A slot boundary while still capturing: flush what we have, left-aligned.
      if (state_q == StCapture) begin
        push      = 1'b1;
        push_data = shift_q << (DATA_WIDTH - bit_cnt_q);
        push_chan = chan_q;
        err_set   = 1'b1;
      end
      chan_d    = start_chan;
      shift_d   = DATA_WIDTH'(sd);
      bit_cnt_d = CW'(1);
      if (DATA_WIDTH == 1) begin
        push      = 1'b1;
        push_data = DATA_WIDTH'(sd);
        push_chan = start_chan;
        state_d   = StSkip;
      end else begin
        state_d = StCapture;
      end
    end else if (state_q != StUnsync) begin
      // Saturates so overlong I2S halves cannot wrap the counter.
      if (bit_cnt_q != CW'(SLOT_WIDTH)) bit_cnt_d = bit_cnt_q + 1'b1;
      if (state_q == StCapture) begin
        shift_d = (shift_q << 1) | DATA_WIDTH'(sd);
        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
          push      = 1'b1;
          push_data = shift_d;
          state_d   = StSkip;
        end
      end
    end
  end

  assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && m_ready;
  assign wr_ok   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StUnsync;
      ws_q        <= 1'b0;
      ws_qq       <= 1'b0;
      bit_cnt_q   <= '0;
      chan_q      <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q   <= state_d;
      ws_q      <= ws;
      ws_qq     <= ws_q;
      bit_cnt_q <= bit_cnt_d;
      chan_q    <= chan_d;
      shift_q   <= shift_d;
      if (ovf_set)         overflow_q <= 1'b1;
      else if (clr_status) overflow_q <= 1'b0;
      if (err_set)         frame_err_q <= 1'b1;
      else if (clr_status) frame_err_q <= 1'b0;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_ok && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge sck) begin
    if (wr_ok) mem[wr_ptr_q] <= {push_chan, (push_chan == LastChan), push_data};
  end

  assign m_valid = (count_q != '0);
  assign {m_chan, m_last, m_data} = m_valid ? mem[rd_ptr_q] : '0;
  assign synced    = (state_q != StUnsync);
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_tdm_receiver.sv
// Bench for i2s_tdm_receiver: an I2S instance and a 4-slot TDM instance share the serial
// pins; expected words are queued at stimulus time and popped by per-instance monitors.
module tb_i2s_tdm_receiver;

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  chan;
    logic        last;
  } word_t;

  logic sck = 1'b0;
  always #5 sck = ~sck;

  logic reset_n, sd, ws, clr_status, en_a, en_b, rdy_a, rdy_b;
  logic [23:0] data_a;
  logic [0:0]  chan_a;
  logic        last_a, valid_a, synced_a, ovf_a, ferr_a;
  logic [15:0] data_b;
  logic [1:0]  chan_b;
  logic        last_b, valid_b, synced_b, ovf_b, ferr_b;

  word_t q_a[$];
  word_t q_b[$];
  word_t exp_a, exp_b;
  int n_checks = 0;
  int n_pass   = 0;
  int rdy_pulse_at = -1;
  int clr_at = -1;

  i2s_tdm_receiver dut_a (
    .sck(sck), .reset_n(reset_n), .en(en_a), .sd(sd), .ws(ws),
    .m_data(data_a), .m_chan(chan_a), .m_last(last_a), .m_valid(valid_a), .m_ready(rdy_a),
    .synced(synced_a), .overflow(ovf_a), .frame_err(ferr_a), .clr_status(clr_status)
  );

  i2s_tdm_receiver #(
    .DATA_WIDTH(16), .SLOT_WIDTH(32), .CHANNELS(4), .TDM_MODE(1), .DATA_DELAY(1),
    .FIFO_DEPTH(4)
  ) dut_b (
    .sck(sck), .reset_n(reset_n), .en(en_b), .sd(sd), .ws(ws),
    .m_data(data_b), .m_chan(chan_b), .m_last(last_b), .m_valid(valid_b), .m_ready(rdy_b),
    .synced(synced_b), .overflow(ovf_b), .frame_err(ferr_b), .clr_status(clr_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Outputs are stable between the negedge and the next posedge, where the handshake happens.
  always @(negedge sck) begin
    if (reset_n && valid_a && rdy_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected: got word 0x%0h chan %0d, expected none", data_a, chan_a);
      end else begin
        exp_a = q_a.pop_front();
        check("a_word", {5'b0, data_a, 1'b0, chan_a, last_a}, {5'b0, exp_a});
      end
    end
    if (reset_n && valid_b && rdy_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected: got word 0x%0h chan %0d, expected none", data_b, chan_b);
      end else begin
        exp_b = q_b.pop_front();
        check("b_word", {5'b0, data_b, 8'h00, chan_b, last_b}, {5'b0, exp_b});
      end
    end
  end

  // One bit per sck; ws takes w_last on the final bit so the next slot starts after it.
  task automatic send_slot(input logic [31:0] word, input int len, input logic w_body,
                           input logic w_last);
    for (int i = 0; i < len; i++) begin
      @(posedge sck);
      #2;
      sd = (i < 32) ? word[31-i] : 1'b0;
      ws = (i == len - 1) ? w_last : w_body;
      if (rdy_pulse_at >= 0) rdy_a = (i == rdy_pulse_at);
      clr_status = (i == clr_at);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sck);
      #2;
    end
  endtask

  task automatic pulse_clr();
    @(posedge sck);
    #2 clr_status = 1'b1;
    @(posedge sck);
    #2 clr_status = 1'b0;
  endtask

  task automatic push_a(input logic [23:0] d, input logic c);
    q_a.push_back('{data: d, chan: {1'b0, c}, last: c});
  endtask

  task automatic push_b(input logic [15:0] d, input logic [1:0] c);
    q_b.push_back('{data: {d, 8'h00}, chan: c, last: (c == 2'd3)});
  endtask

  initial begin
    reset_n = 1'b0; en_a = 1'b0; en_b = 1'b0; ws = 1'b1; sd = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1; clr_status = 1'b0;
    idle(3);
    check("rst_valid_a", valid_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_synced_a", synced_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_ferr_a", ferr_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_synced_b", synced_b, 0);
    reset_n = 1'b1;
    en_a = 1'b1;

    // I2S, starting mid-frame with ws high
    send_slot(32'hDEAD_BEEF, 12, 1'b1, 1'b1);
    check("mid_nosync", synced_a, 0);
    check("mid_novalid", valid_a, 0);
    send_slot(32'hFFFF_FFFF, 4, 1'b1, 1'b0);
    check("pre_fall_nosync", synced_a, 0);
    push_a(24'hABCDEF, 1'b0);
    push_a(24'h123456, 1'b1);
    push_a(24'h5A5A5A, 1'b0);
    push_a(24'hC3C3C3, 1'b1);
    send_slot({24'hABCDEF, 8'h5A}, 32, 1'b0, 1'b1);
    check("synced_after_fall", synced_a, 1);
    send_slot({24'h123456, 8'hC3}, 32, 1'b1, 1'b0);
    send_slot({24'h5A5A5A, 8'h00}, 32, 1'b0, 1'b1);
    send_slot({24'hC3C3C3, 8'hFF}, 32, 1'b1, 1'b0);
    idle(3);
    check("i2s_no_ferr", ferr_a, 0);
    en_a = 1'b0;
    idle(2);
    check("en_low_unsync", synced_a, 0);

    // I2S short right half
    en_a = 1'b1;
    send_slot(32'h0, 3, 1'b0, 1'b1);
    send_slot(32'h0, 3, 1'b1, 1'b0);
    push_a(24'h654321, 1'b0);
    push_a(24'hB2C000, 1'b1);
    push_a(24'h0F1E2D, 1'b0);
    push_a(24'hE1D2C3, 1'b1);
    send_slot({24'h654321, 8'h0F}, 32, 1'b0, 1'b1);
    send_slot(32'hB2FF_FFFF, 10, 1'b1, 1'b0);
    send_slot({24'h0F1E2D, 8'hAA}, 32, 1'b0, 1'b1);
    check("short_ferr", ferr_a, 1);
    send_slot({24'hE1D2C3, 8'h00}, 32, 1'b1, 1'b0);
    idle(2);
    en_a = 1'b0;
    idle(2);
    pulse_clr();
    check("short_ferr_clr", ferr_a, 0);
    check("short_no_ovf", ovf_a, 0);

    // FIFO full: four held, push+pop at full, then a dropped word
    rdy_a = 1'b0;
    en_a  = 1'b1;
    send_slot(32'h0, 3, 1'b0, 1'b1);
    send_slot(32'h0, 3, 1'b1, 1'b0);
    push_a(24'h100001, 1'b0);
    push_a(24'h200002, 1'b1);
    push_a(24'h300003, 1'b0);
    push_a(24'h400004, 1'b1);
    push_a(24'h500005, 1'b0);
    send_slot({24'h100001, 8'h00}, 32, 1'b0, 1'b1);
    send_slot({24'h200002, 8'h00}, 32, 1'b1, 1'b0);
    send_slot({24'h300003, 8'h00}, 32, 1'b0, 1'b1);
    send_slot({24'h400004, 8'h00}, 32, 1'b1, 1'b0);
    check("full_valid", valid_a, 1);
    check("full_no_ovf", ovf_a, 0);
    rdy_pulse_at = 23;
    send_slot({24'h500005, 8'h00}, 32, 1'b0, 1'b1);
    rdy_pulse_at = -1;
    check("pushpop_no_ovf", ovf_a, 0);
    send_slot({24'h600006, 8'h00}, 32, 1'b1, 1'b0);
    check("drop_ovf", ovf_a, 1);
    en_a = 1'b0;
    idle(1);
    rdy_a = 1'b1;
    idle(8);
    check("drained", valid_a, 0);
    pulse_clr();
    check("ovf_clr", ovf_a, 0);

    // Reset in the middle of a slot with words and flags pending
    rdy_a = 1'b0;
    en_a  = 1'b1;
    send_slot(32'h0, 3, 1'b0, 1'b1);
    send_slot(32'h0, 3, 1'b1, 1'b0);
    send_slot({24'hCAFE00, 8'h00}, 10, 1'b0, 1'b1);
    send_slot(32'hFFFF_0000, 14, 1'b1, 1'b1);
    check("prerst_valid", valid_a, 1);
    check("prerst_ferr", ferr_a, 1);
    check("prerst_synced", synced_a, 1);
    reset_n = 1'b0;
    idle(2);
    check("rst_mid_valid", valid_a, 0);
    check("rst_mid_ferr", ferr_a, 0);
    check("rst_mid_synced", synced_a, 0);
    check("rst_mid_ovf", ovf_a, 0);
    reset_n = 1'b1;
    rdy_a = 1'b1;
    send_slot(32'h0, 6, 1'b1, 1'b1);
    check("post_rst_unsync", synced_a, 0);
    send_slot(32'h0, 2, 1'b1, 1'b0);
    push_a(24'h0A0B0C, 1'b0);
    send_slot({24'h0A0B0C, 8'h00}, 32, 1'b0, 1'b1);
    check("post_rst_synced", synced_a, 1);
    en_a = 1'b0;
    idle(3);

    // TDM, two clean frames
    en_b = 1'b1;
    send_slot(32'h0, 4, 1'b0, 1'b1);
    push_b(16'h1111, 2'd0); push_b(16'h2222, 2'd1);
    push_b(16'h3333, 2'd2); push_b(16'h4444, 2'd3);
    push_b(16'hAAAA, 2'd0); push_b(16'h5555, 2'd1);
    push_b(16'h0F0F, 2'd2); push_b(16'hF0F0, 2'd3);
    send_slot({16'h1111, 16'hFFFF}, 32, 1'b0, 1'b0);
    send_slot({16'h2222, 16'h0000}, 32, 1'b0, 1'b0);
    send_slot({16'h3333, 16'hFFFF}, 32, 1'b0, 1'b0);
    send_slot({16'h4444, 16'h0000}, 32, 1'b0, 1'b1);
    send_slot({16'hAAAA, 16'h0000}, 32, 1'b0, 1'b0);
    send_slot({16'h5555, 16'hFFFF}, 32, 1'b0, 1'b0);
    send_slot({16'h0F0F, 16'h0000}, 32, 1'b0, 1'b0);
    send_slot({16'hF0F0, 16'hFFFF}, 32, 1'b0, 1'b1);
    idle(3);
    check("tdm_no_ferr", ferr_b, 0);
    check("tdm_synced", synced_b, 1);
    en_b = 1'b0;
    idle(2);

    // TDM misplaced frame start, then a frame with its sync missing
    en_b = 1'b1;
    send_slot(32'h0, 4, 1'b0, 1'b1);
    push_b(16'h1234, 2'd0); push_b(16'h5678, 2'd1);
    push_b(16'hBEEF, 2'd0); push_b(16'h2468, 2'd1);
    push_b(16'h1357, 2'd2); push_b(16'h9ABC, 2'd3);
    send_slot({16'h1234, 16'h0000}, 32, 1'b0, 1'b0);
    send_slot({16'h5678, 16'hFFFF}, 20, 1'b0, 1'b1);
    clr_at = 5;
    send_slot({16'hBEEF, 16'h0000}, 32, 1'b0, 1'b0);
    clr_at = -1;
    check("misplaced_cleared", ferr_b, 0);
    send_slot({16'h2468, 16'h0000}, 32, 1'b0, 1'b0);
    send_slot({16'h1357, 16'h0000}, 32, 1'b0, 1'b0);
    check("tdm_still_synced", synced_b, 1);
    send_slot({16'h9ABC, 16'h0000}, 32, 1'b0, 1'b0);
    idle(3);
    check("nosync_unsync", synced_b, 0);
    check("nosync_ferr", ferr_b, 1);
    en_b = 1'b0;
    pulse_clr();
    check("tdm_ferr_clr", ferr_b, 0);

    idle(5);
    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
